// File: rtl/reg_file_responder_pkg.sv
// reg_file_responder_pkg: shared widths, init value and sweep FSM state type
package reg_file_responder_pkg;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [XLEN-1:0] INIT_VALUE = '0;
  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;
endpackage

// File: rtl/reg_file_responder_if.sv
// reg_file_responder_if: ID/WB <-> register file bus; master = pipeline side, slave = register file
interface reg_file_responder_if
  import reg_file_responder_pkg::*;
();
  logic  op_write;
  addr_t write_addr;
  xlen_t write_data;
  logic  rd_en;
  addr_t rd_addr1;
  addr_t rd_addr2;
  xlen_t rd_data1;
  xlen_t rd_data2;
  logic  rd_valid;
  logic  init_done;
  logic  wr_err;
  modport master (
    output op_write, write_addr, write_data, rd_en, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, rd_valid, init_done, wr_err
  );
  modport slave (
    input  op_write, write_addr, write_data, rd_en, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, rd_valid, init_done, wr_err
  );
endinterface

// File: rtl/reg_file_responder_init_sweep.sv
// reg_file_responder_init_sweep: post-reset sweep counter + INIT/RUN FSM
//   clk, reset     : clock, async active-high reset
//   sweep_we_o     : array write enable while sweeping
//   sweep_addr_o   : register being cleared (1..NUM_REGS-1)
//   init_done_o    : high once in RUN
module reg_file_responder_init_sweep
  import reg_file_responder_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  output logic  sweep_we_o,
  output addr_t sweep_addr_o,
  output logic  init_done_o
);
  rf_state_t state_q, state_d;
  addr_t     cnt_q, cnt_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= RF_INIT;
      cnt_q   <= addr_t'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = (state_q == RF_INIT && cnt_q == addr_t'(NUM_REGS - 1)) ? RF_RUN : state_q;
    cnt_d   = (state_q == RF_INIT) ? cnt_q + addr_t'(1) : cnt_q;
  end
  always_comb begin
    sweep_we_o   = state_q == RF_INIT;
    sweep_addr_o = cnt_q;
    init_done_o  = state_q == RF_RUN;
  end
endmodule

// File: rtl/reg_file_responder.sv
// reg_file_responder: x0-hardwired register file with init sweep, registered reads and WB bypass
//   clk, reset : clock, async active-high reset
//   bus        : slave side of reg_file_responder_if (write-back, dual read, status)
module reg_file_responder
  import reg_file_responder_pkg::*;
(
  input  logic clk,
  input  logic reset,
  reg_file_responder_if.slave bus
);
  logic  sweep_we, init_done, wb_we, arr_we;
  addr_t sweep_addr, arr_addr;
  xlen_t arr_data;
  xlen_t regs_q [1:NUM_REGS-1];
  xlen_t rd_data1_q, rd_data1_d, rd_data2_q, rd_data2_d;
  logic  rd_valid_q, wr_err_q;
  reg_file_responder_init_sweep u_sweep (
    .clk          (clk),
    .reset        (reset),
    .sweep_we_o   (sweep_we),
    .sweep_addr_o (sweep_addr),
    .init_done_o  (init_done)
  );
  // Write-back is only honoured in RUN, so the sweep owns the write port during INIT.
  assign wb_we    = init_done & bus.op_write & (bus.write_addr != '0);
  assign arr_we   = sweep_we | wb_we;
  assign arr_addr = sweep_we ? sweep_addr : bus.write_addr;
  assign arr_data = sweep_we ? INIT_VALUE : bus.write_data;
  always_ff @(posedge clk)
    if (arr_we) regs_q[arr_addr] <= arr_data;
  always_comb begin
    rd_data1_d = (bus.rd_addr1 == '0) ? '0 :
                 (wb_we && bus.write_addr == bus.rd_addr1) ? bus.write_data : regs_q[bus.rd_addr1];
    rd_data2_d = (bus.rd_addr2 == '0) ? '0 :
                 (wb_we && bus.write_addr == bus.rd_addr2) ? bus.write_data : regs_q[bus.rd_addr2];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= init_done & bus.rd_en;
      if (init_done && bus.rd_en) begin
        rd_data1_q <= rd_data1_d;
        rd_data2_q <= rd_data2_d;
      end
      wr_err_q <= wr_err_q | (~init_done & bus.op_write);
    end
  assign bus.rd_data1  = rd_data1_q;
  assign bus.rd_data2  = rd_data2_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.init_done = init_done;
  assign bus.wr_err    = wr_err_q;
endmodule

// File: tb/tb_reg_file_responder.sv
// tb_reg_file_responder: randomized self-checking bench against an array model of the register file
module tb_reg_file_responder;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  logic [31:0] m [32];
  reg_file_responder_if bus();
  reg_file_responder dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task step;
    @(posedge clk);
    #1;
  endtask
  task idle;
    bus.op_write = 0;
    bus.write_addr = 0;
    bus.write_data = 0;
    bus.rd_en = 0;
    bus.rd_addr1 = 0;
    bus.rd_addr2 = 0;
  endtask
  task clear_model;
    for (int i = 0; i < 32; i++) m[i] = 0;
  endtask
  task apply_reset;
    reset = 1;
    clear_model();
    repeat (3) step();
    reset = 0;
  endtask
  task wait_init(output int n);
    n = 0;
    while (!bus.init_done && n < 200) begin
      step();
      n++;
    end
  endtask
  task test_reset;
    int n;
    logic [31:0] p1, p2;
    idle();
    reset = 1;
    clear_model();
    #1;
    checks++; if ({bus.rd_data1, bus.rd_data2} !== 64'h0) begin errors++; $display("FAIL reset_data got %h %h want 0 0", bus.rd_data1, bus.rd_data2); end
    checks++; if ({bus.rd_valid, bus.init_done, bus.wr_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bus.rd_valid, bus.init_done, bus.wr_err}); end
    repeat (3) step();
    reset = 0;
    wait_init(n);
    checks++; if (n !== 31) begin errors++; $display("FAIL init_len got %0d want 31", n); end
    for (int a = 0; a < 32; a++) begin
      bus.rd_en = 1;
      bus.rd_addr1 = 5'(a);
      bus.rd_addr2 = 5'(31 - a);
      step();
      checks++; if (bus.rd_data1 !== m[a] || bus.rd_data2 !== m[31-a] || bus.rd_valid !== 1'b1) begin
        errors++; $display("FAIL init_read a=%0d got %h %h v=%b want %h %h v=1", a, bus.rd_data1, bus.rd_data2, bus.rd_valid, m[a], m[31-a]);
      end
    end
    p1 = bus.rd_data1;
    p2 = bus.rd_data2;
    idle();
    step();
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data1 !== p1 || bus.rd_data2 !== p2) begin
      errors++; $display("FAIL read_hold got %h %h v=%b want %h %h v=0", bus.rd_data1, bus.rd_data2, bus.rd_valid, p1, p2);
    end
  endtask
  task test_write_read;
    bus.op_write = 1; bus.write_addr = 5; bus.write_data = 32'hDEADBEEF;
    step();
    m[5] = 32'hDEADBEEF;
    idle();
    bus.rd_en = 1; bus.rd_addr1 = 5;
    step();
    checks++; if (bus.rd_data1 !== m[5] || bus.rd_valid !== 1'b1) begin
      errors++; $display("FAIL write_read got %h v=%b want %h v=1", bus.rd_data1, bus.rd_valid, m[5]);
    end
    idle();
    step();
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL valid_pulse got %h v=%b want deadbeef v=0", bus.rd_data1, bus.rd_valid);
    end
  endtask
  task test_x0;
    bus.op_write = 1; bus.write_addr = 0; bus.write_data = 32'hFFFFFFFF;
    step();
    idle();
    bus.rd_en = 1;
    step();
    checks++; if (bus.rd_data1 !== 32'h0 || bus.rd_data2 !== 32'h0) begin
      errors++; $display("FAIL x0_read got %h %h want 0 0", bus.rd_data1, bus.rd_data2);
    end
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL x0_wr_err got %b want 0", bus.wr_err); end
    idle();
  endtask
  task test_bypass;
    bus.op_write = 1; bus.write_addr = 8; bus.write_data = 32'h55;
    step();
    m[8] = 32'h55;
    bus.write_addr = 7; bus.write_data = 32'h12345678;
    bus.rd_en = 1; bus.rd_addr1 = 7; bus.rd_addr2 = 8;
    step();
    m[7] = 32'h12345678;
    checks++; if (bus.rd_data1 !== 32'h12345678 || bus.rd_data2 !== 32'h55) begin
      errors++; $display("FAIL bypass got %h %h want 12345678 00000055", bus.rd_data1, bus.rd_data2);
    end
    idle();
  endtask
  task test_random;
    logic we, re;
    logic [4:0] wa, a1, a2;
    logic [31:0] wd, e1, e2;
    e1 = bus.rd_data1;
    e2 = bus.rd_data2;
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      wd = $urandom;
      bus.op_write = we; bus.write_addr = wa; bus.write_data = wd;
      bus.rd_en = re; bus.rd_addr1 = a1; bus.rd_addr2 = a2;
      if (re) begin
        e1 = (a1 == 0) ? 0 : (we && wa == a1) ? wd : m[a1];
        e2 = (a2 == 0) ? 0 : (we && wa == a2) ? wd : m[a2];
      end
      step();
      if (we && wa != 0) m[wa] = wd;
      checks++; if (bus.rd_data1 !== e1 || bus.rd_data2 !== e2 || bus.rd_valid !== re) begin
        errors++; $display("FAIL random i=%0d got %h %h v=%b want %h %h v=%b", i, bus.rd_data1, bus.rd_data2, bus.rd_valid, e1, e2, re);
      end
    end
    idle();
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL random_wr_err got %b want 0", bus.wr_err); end
  endtask
  task test_init_write;
    int n;
    apply_reset();
    repeat (9) step();
    checks++; if (bus.wr_err !== 1'b0 || bus.init_done !== 1'b0) begin
      errors++; $display("FAIL init_pre got err=%b done=%b want 0 0", bus.wr_err, bus.init_done);
    end
    bus.op_write = 1; bus.write_addr = 3; bus.write_data = 32'hA;
    bus.rd_en = 1; bus.rd_addr1 = 3;
    step();
    idle();
    checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL init_wr_err got %b want 1", bus.wr_err); end
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data1 !== 32'h0) begin
      errors++; $display("FAIL init_read_ignored got %h v=%b want 0 v=0", bus.rd_data1, bus.rd_valid);
    end
    wait_init(n);
    checks++; if (n !== 21) begin errors++; $display("FAIL init_remaining got %0d want 21", n); end
    bus.rd_en = 1; bus.rd_addr1 = 3;
    step();
    idle();
    checks++; if (bus.rd_data1 !== 32'h0 || bus.wr_err !== 1'b1) begin
      errors++; $display("FAIL init_x3 got %h err=%b want 0 err=1", bus.rd_data1, bus.wr_err);
    end
  endtask
  task test_reset_mid_init;
    int n;
    bus.op_write = 1; bus.write_addr = 9; bus.write_data = 32'h99;
    step();
    idle();
    bus.rd_en = 1; bus.rd_addr1 = 9;
    step();
    idle();
    checks++; if (bus.rd_data1 !== 32'h99) begin errors++; $display("FAIL x9_pre got %h want 99", bus.rd_data1); end
    apply_reset();
    repeat (5) step();
    bus.op_write = 1; bus.write_addr = 4;
    step();
    idle();
    repeat (9) step();
    reset = 1;
    #1;
    checks++; if (bus.wr_err !== 1'b0 || bus.init_done !== 1'b0 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset got err=%b done=%b v=%b want 0 0 0", bus.wr_err, bus.init_done, bus.rd_valid);
    end
    clear_model();
    repeat (3) step();
    reset = 0;
    wait_init(n);
    checks++; if (n !== 31) begin errors++; $display("FAIL mid_init_len got %0d want 31", n); end
    bus.rd_en = 1; bus.rd_addr1 = 9; bus.rd_addr2 = 9;
    step();
    idle();
    checks++; if (bus.rd_data1 !== m[9] || bus.rd_data2 !== m[9] || bus.wr_err !== 1'b0) begin
      errors++; $display("FAIL x9_post got %h %h err=%b want %h %h err=0", bus.rd_data1, bus.rd_data2, bus.wr_err, m[9], m[9]);
    end
  endtask
  initial begin
    idle();
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_random();
    test_init_write();
    test_reset_mid_init();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
